// File: rtl/seq101_pkg.sv
// Shared types and transition tables for the bit-serial "101" Mealy detector.
package seq101_pkg;

    typedef enum logic [1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2
    } det_state_t;

    // The unused encoding 2'd3 falls into the default arm and behaves as A.
    function automatic det_state_t det_next(input logic [1:0] s, input logic x);
        case (s)
            2'd1:    return x ? ST_B : ST_C;
            2'd2:    return x ? ST_B : ST_A;
            default: return x ? ST_B : ST_A;
        endcase
    endfunction

    function automatic logic det_z(input logic [1:0] s, input logic x);
        return (s == 2'd2) && x;
    endfunction

endpackage

// File: rtl/seq101_core.sv
// Combinational "101" detector step, shared by all channels of the scheduler.
module seq101_core
    import seq101_pkg::*;
(
    input  logic [1:0] state,
    input  logic       x,
    output det_state_t next_state,
    output logic       z
);

    assign next_state = det_next(state, x);
    assign z          = det_z(state, x);

endmodule

// File: rtl/seq101_rr_sched.sv
// Round-robin scheduler time-sharing one "101" detector core across N serial channels.
module seq101_rr_sched
    import seq101_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   bit_in,
    input  logic [N-1:0]   clear,
    output logic [N-1:0]   gnt,
    output logic           hit,
    output logic [IDW-1:0] hit_id
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   scan;
    logic           found;
    det_state_t     st [N];
    det_state_t     st_eff;
    det_state_t     core_next;
    logic           core_z;

    // Scan upward from ptr with wrap; the first requester wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                scan = {1'b0, ptr} + (IDW+1)'(k);
                if (scan >= (IDW+1)'(N))
                    scan = scan - (IDW+1)'(N);
                if (!found && req[scan[IDW-1:0]]) begin
                    found   = 1'b1;
                    gnt_idx = scan[IDW-1:0];
                end
            end
        end
    end

    assign gnt    = found ? (N'(1) << gnt_idx) : '0;
    assign st_eff = clear[gnt_idx] ? ST_A : st[gnt_idx];

    seq101_core u_core (
        .state      (st_eff),
        .x          (bit_in[gnt_idx]),
        .next_state (core_next),
        .z          (core_z)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the state array is reset entry by entry; each entry is live FSM state, not bulk storage.
            for (int i = 0; i < N; i++)
                st[i] <= ST_A;
            ptr    <= '0;
            hit    <= 1'b0;
            hit_id <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (clear[i])
                    st[i] <= ST_A;
            // NOTE: non-blocking writes; the later write-back to the granted entry overrides its clear.
            if (found) begin
                st[gnt_idx] <= core_next;
                ptr         <= (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + IDW'(1);
            end
            hit <= found & core_z;
            if (found & core_z)
                hit_id <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_seq101_rr_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a bit-history model.
module tb_seq101_rr_sched;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, bit_in, clear, gnt;
    logic           hit;
    logic [IDW-1:0] hit_id;

    always #5 clk = ~clk;

    seq101_rr_sched #(.N(N), .IDW(IDW)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .bit_in (bit_in),
        .clear  (clear),
        .gnt    (gnt),
        .hit    (hit),
        .hit_id (hit_id)
    );

    int n_vec = 0;
    int n_err = 0;
    int hit_seen = 0;

    // Model: per channel, the last two bits consumed since the last clear/reset.
    int m_ptr;
    int m_len [N];
    bit m_old [N];
    bit m_new [N];
    bit m_hit;
    int m_id;

    bit strm [N][64];
    int wr [N];
    int rd [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(m_ptr + k) % N])
                return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_hit = 1'b0;
        m_id  = 0;
        for (int i = 0; i < N; i++) m_len[i] = 0;
    endtask

    task automatic cycle(input logic rst, input logic [N-1:0] r, input logic [N-1:0] b,
                         input logic [N-1:0] c, output int g, output logic [N-1:0] gs);
        bit x;
        reset  = rst;
        req    = r;
        bit_in = b;
        clear  = c;
        @(negedge clk);
        g  = rst ? -1 : model_grant(r);
        gs = gnt;
        check("gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
        check("hit", 32'(hit), 32'(m_hit));
        check("hit_id", 32'(hit_id), 32'(m_id));
        if (hit === 1'b1) hit_seen++;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++)
                if (c[i]) m_len[i] = 0;
            m_hit = 1'b0;
            if (g >= 0) begin
                x     = b[g];
                m_hit = (m_len[g] >= 2) && m_old[g] && !m_new[g] && x;
                if (m_hit) m_id = g;
                m_old[g] = m_new[g];
                m_new[g] = x;
                if (m_len[g] < 2) m_len[g]++;
                m_ptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end
    endtask

    task automatic push(input int ch, input logic [7:0] bits, input int n);
        for (int j = n - 1; j >= 0; j--) begin
            strm[ch][wr[ch]] = bits[j];
            wr[ch]++;
        end
    endtask

    // Feeds queued bits with req held per channel until each bit is granted.
    task automatic drain(input int budget);
        int g;
        int left;
        logic [N-1:0] r, b, gs;
        for (int k = 0; k < budget; k++) begin
            r = '0;
            b = '0;
            for (int i = 0; i < N; i++)
                if (rd[i] < wr[i]) begin
                    r[i] = 1'b1;
                    b[i] = strm[i][rd[i]];
                end
            if (r == '0) break;
            cycle(1'b0, r, b, '0, g, gs);
            if (g >= 0) rd[g]++;
        end
        left = 0;
        for (int i = 0; i < N; i++) left += wr[i] - rd[i];
        check("drain_budget", 32'(left), 32'd0);
    endtask

    task automatic do_reset();
        int g;
        logic [N-1:0] gs;
        cycle(1'b1, '0, '0, '0, g, gs);
        flush();
    endtask

    initial begin
        int g, h0;
        logic [N-1:0] gs, r, b, c;
        bit pend [N];
        bit pbit [N];

        reset = 1'b1; req = '0; bit_in = '0; clear = '0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_hit_id", 32'(hit_id), 32'd0);

        // ch0 alone: 1,0,1 -> hit on ch0
        do_reset();
        push(0, 8'b101, 3);
        drain(10);
        check("t1_hit", 32'(hit), 32'd1);
        check("t1_hit_id", 32'(hit_id), 32'd0);
        cycle(1'b0, '0, '0, '0, g, gs);

        // all four requesting: grants rotate 0,1,2,3,0,...
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 4'b1111, 4'b0000, '0, g, gs);
            check("rr_gnt", 32'(gs), 32'd1 << (k % 4));
        end

        // interleaved ch1 "101" and ch2 "1101"
        do_reset();
        h0 = hit_seen;
        push(1, 8'b101, 3);
        push(2, 8'b1101, 4);
        drain(20);
        cycle(1'b0, '0, '0, '0, g, gs);
        check("ilv_hits", 32'(hit_seen - h0), 32'd2);

        // overlap on ch3: 10101 -> two hits
        do_reset();
        push(3, 8'b10101, 5);
        h0 = hit_seen;
        drain(20);
        cycle(1'b0, '0, '0, '0, g, gs);
        check("ovl_hits", 32'(hit_seen - h0), 32'd2);

        // clear with a bit in the same cycle: bit is evaluated from A
        do_reset();
        h0 = hit_seen;
        cycle(1'b0, 4'b0001, 4'b0001, 4'b0000, g, gs);
        cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, g, gs);
        cycle(1'b0, 4'b0001, 4'b0001, 4'b0001, g, gs);
        cycle(1'b0, '0, '0, '0, g, gs);
        check("clr_nohit", 32'(hit_seen - h0), 32'd0);
        cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, g, gs);
        cycle(1'b0, 4'b0001, 4'b0001, 4'b0000, g, gs);
        cycle(1'b0, '0, '0, '0, g, gs);
        check("clr_hit", 32'(hit_seen - h0), 32'd1);

        // reset mid-pattern on ch2
        do_reset();
        cycle(1'b0, 4'b0100, 4'b0100, '0, g, gs);
        cycle(1'b0, 4'b0100, 4'b0000, '0, g, gs);
        cycle(1'b1, 4'b0100, 4'b0100, '0, g, gs);
        check("rst_gnt", 32'(gs), 32'd0);
        h0 = hit_seen;
        cycle(1'b0, 4'b0101, 4'b0101, '0, g, gs);
        check("rst_ptr", 32'(gs), 32'b0001);
        cycle(1'b0, 4'b0100, 4'b0100, '0, g, gs);
        check("rst_ch2", 32'(gs), 32'b0100);
        cycle(1'b0, '0, '0, '0, g, gs);
        check("rst_nohit", 32'(hit_seen - h0), 32'd0);

        // random traffic: held requests, sporadic clears and resets
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
                    pend[i] = 1'b1;
                    pbit[i] = 1'($urandom_range(1, 0));
                end
                r[i] = pend[i];
                b[i] = pbit[i];
                c[i] = ($urandom_range(15, 0) == 0);
            end
            cycle(($urandom_range(127, 0) == 0), r, b, c, g, gs);
            if (g >= 0) pend[g] = 1'b0;
        end
        cycle(1'b0, '0, '0, '0, g, gs);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
